uart_receiver: RTL and testbench

Receive side of the team's UART link: recovers 8N1 frames from the serial line `i_rx` using a 16× oversampling tick and buffers received bytes in an 8-entry FIFO for the host logic to drain. It is the counterpart of the existing FIFO-fronted UART transmitter. It shares the same clock and reset and the same baud generator, which runs at 16× rate for this block.

---
 rtl/uart_receiver.sv | 162 ++++++++++++++++
 tb/tb_uart_receiver.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART receiver: 8N1 frames (8E1 when UART_RX_PARITY_EN is defined), 16x oversampled, into an 8-entry show-ahead FIFO.
// Latency: byte on o_data and error pulses appear one cycle after the stop-bit mid-sample edge.
// Backpressure: none toward the line; a good frame arriving while the FIFO is full (and not being read) is dropped and flagged on o_overrun.
module uart_receiver (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_baud16,
    input  logic       i_rx,
    input  logic       i_read,
    output logic [7:0] o_data,
    output logic       o_empty,
    output logic       o_full,
    output logic       o_overrun,
    output logic       o_frame_err,
    output logic       o_parity_err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_AFTER_DATA = S_PARITY;
`else
    localparam logic [2:0] S_AFTER_DATA = S_STOP;
`endif

    logic       rx_m;
    logic       rx_s;
    logic [2:0] state;
    logic [3:0] tc;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic       par_err;
    logic       stop_smp;
    logic       push;

    logic [7:0] mem [0:7];
    logic [2:0] wr_ptr;
    logic [2:0] rd_ptr;
    logic [3:0] count;
    logic       rd_en;
    logic       wr_en;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= i_rx;
            rx_s <= rx_m;
        end
    end

    assign stop_smp = (state == S_STOP) && i_baud16 && (tc == 4'd15);
    assign push     = stop_smp && rx_s && !par_err;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state       <= S_IDLE;
            tc          <= 4'd0;
            bit_idx     <= 3'd0;
            shreg       <= 8'd0;
            o_frame_err <= 1'b0;
        end else begin
            o_frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    tc      <= 4'd0;
                    bit_idx <= 3'd0;
                    if (!rx_s) state <= S_START;
                end
                S_START: if (i_baud16) begin
                    // Mid-bit of the start bit: a high line here was only a glitch.
                    if (tc == 4'd7) begin
                        tc    <= 4'd0;
                        state <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        tc <= tc + 4'd1;
                    end
                end
                S_DATA: if (i_baud16) begin
                    tc <= tc + 4'd1;
                    if (tc == 4'd15) begin
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= S_AFTER_DATA;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: if (i_baud16) begin
                    tc <= tc + 4'd1;
                    if (tc == 4'd15) state <= S_STOP;
                end
`endif
                S_STOP: if (i_baud16) begin
                    tc <= tc + 4'd1;
                    if (tc == 4'd15) begin
                        if (rx_s) begin
                            state <= S_IDLE;
                        end else begin
                            o_frame_err <= 1'b1;
                            state       <= S_BREAK;
                        end
                    end
                end
                // Hold off until the line returns high so a long break is not read as new frames.
                S_BREAK: if (rx_s) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            par_err      <= 1'b0;
            o_parity_err <= 1'b0;
        end else begin
            if ((state == S_PARITY) && i_baud16 && (tc == 4'd15))
                par_err <= rx_s ^ (^shreg);
            o_parity_err <= stop_smp && rx_s && par_err;
        end
    end
`else
    assign par_err      = 1'b0;
    assign o_parity_err = 1'b0;
`endif

    // A read on an empty FIFO is ignored; a push into a full FIFO only lands if a read frees the slot.
    assign rd_en = i_read && (count != 4'd0);
    assign wr_en = push && ((count != 4'd8) || rd_en);

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            wr_ptr    <= 3'd0;
            rd_ptr    <= 3'd0;
            count     <= 4'd0;
            o_overrun <= 1'b0;
        end else begin
            o_overrun <= push && (count == 4'd8) && !rd_en;
            if (wr_en) wr_ptr <= wr_ptr + 3'd1;
            if (rd_en) rd_ptr <= rd_ptr + 3'd1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    assign o_data  = mem[rd_ptr];
    assign o_empty = (count == 4'd0);
    assign o_full  = (count == 4'd8);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: table of single frames plus hand-written FIFO, glitch, break, reset and parity sequences.
module tb_uart_receiver;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_baud16 = 1'b0;
    logic       i_rx = 1'b1;
    logic       i_read = 1'b0;
    logic [7:0] o_data;
    logic       o_empty;
    logic       o_full;
    logic       o_overrun;
    logic       o_frame_err;
    logic       o_parity_err;

    uart_receiver dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_baud16     (i_baud16),
        .i_rx         (i_rx),
        .i_read       (i_read),
        .o_data       (o_data),
        .o_empty      (o_empty),
        .o_full       (o_full),
        .o_overrun    (o_overrun),
        .o_frame_err  (o_frame_err),
        .o_parity_err (o_parity_err)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;
    int div = 2;
    int cyc = 0;
    int n_ovr = 0;
    int n_ferr = 0;
    int n_perr = 0;
    int total_perr = 0;

    typedef struct {
        logic [7:0] tx;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_empty;
        int         exp_ferr;
    } vec_t;

    vec_t vecs [0:5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: inputs set by the caller take effect at this edge; outputs sampled 1 time unit later.
    task automatic step();
        @(posedge i_clk);
        #1;
        if (o_overrun)    n_ovr++;
        if (o_frame_err)  n_ferr++;
        if (o_parity_err) begin n_perr++; total_perr++; end
        cyc++;
        i_baud16 = (div == 1) ? 1'b1 : ((cyc % div) == 0);
    endtask

    task automatic clr_cnt();
        n_ovr = 0; n_ferr = 0; n_perr = 0;
    endtask

    task automatic send_level(input logic v, input int ticks);
        i_rx = v;
        repeat (ticks * div) step();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_ticks);
        send_level(1'b0, 16);
        for (int i = 0; i < 8; i++) send_level(d[i], 16);
`ifdef UART_RX_PARITY_EN
        send_level(^d, 16);
`endif
        send_level(stop, stop_ticks);
        send_level(1'b1, 24);
    endtask

    task automatic do_read();
        i_read = 1'b1;
        step();
        i_read = 1'b0;
    endtask

    task automatic do_reset();
        i_rst = 1'b0;
        i_rx  = 1'b1;
        repeat (3) step();
        i_rst = 1'b1;
        step();
    endtask

    // Tick every cycle; reports the edge (counted from the start-bit drive) where o_empty first reads 0,
    // and optionally raises i_read for exactly the cycle ending at edge rd_edge.
    task automatic send_timed(input logic [7:0] d, input int rd_edge, output int first);
        logic [10:0] fb;
        int nb;
`ifdef UART_RX_PARITY_EN
        fb = {1'b1, ^d, d, 1'b0};
        nb = 11;
`else
        fb = {2'b11, d, 1'b0};
        nb = 10;
`endif
        div = 1;
        i_baud16 = 1'b1;
        i_rx = 1'b1;
        repeat (4) step();
        first = -1;
        for (int c = 0; c < nb * 16 + 16; c++) begin
            i_rx   = ((c / 16) < nb) ? fb[c / 16] : 1'b1;
            i_read = ((c + 1) == rd_edge);
            step();
            if (first < 0 && !o_empty) first = c + 1;
        end
        i_read = 1'b0;
        div = 2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int exp_edge;
        logic [7:0] d;
`ifdef UART_RX_PARITY_EN
        exp_edge = 16 * 10 + 11;
`else
        exp_edge = 16 * 9 + 11;
`endif
        vecs[0] = '{tx: 8'hA5, stop: 1'b1, exp_data: 8'hA5, exp_empty: 1'b0, exp_ferr: 0};
        vecs[1] = '{tx: 8'h00, stop: 1'b1, exp_data: 8'h00, exp_empty: 1'b0, exp_ferr: 0};
        vecs[2] = '{tx: 8'hFF, stop: 1'b1, exp_data: 8'hFF, exp_empty: 1'b0, exp_ferr: 0};
        vecs[3] = '{tx: 8'h81, stop: 1'b1, exp_data: 8'h81, exp_empty: 1'b0, exp_ferr: 0};
        vecs[4] = '{tx: 8'h3C, stop: 1'b0, exp_data: 8'h00, exp_empty: 1'b1, exp_ferr: 1};
        vecs[5] = '{tx: 8'h6E, stop: 1'b1, exp_data: 8'h6E, exp_empty: 1'b0, exp_ferr: 0};

        // Reset state
        do_reset();
        chk("rst_empty", o_empty, 1);
        chk("rst_full", o_full, 0);
        chk("rst_ovr", o_overrun, 0);
        chk("rst_ferr", o_frame_err, 0);
        chk("rst_perr", o_parity_err, 0);

        // Single frame with exact push latency
        send_timed(8'hA5, -1, first);
        chk("latency_edge", first, exp_edge);
        chk("single_data", o_data, 8'hA5);
        do_read();
        chk("single_empty_after_read", o_empty, 1);

        // Table of frames
        for (int i = 0; i < 6; i++) begin
            clr_cnt();
            send_frame(vecs[i].tx, vecs[i].stop, 16);
            chk($sformatf("vec%0d_empty", i), o_empty, vecs[i].exp_empty);
            chk($sformatf("vec%0d_ferr", i), n_ferr, vecs[i].exp_ferr);
            chk($sformatf("vec%0d_ovr", i), n_ovr, 0);
            if (!vecs[i].exp_empty) begin
                chk($sformatf("vec%0d_data", i), o_data, vecs[i].exp_data);
                do_read();
                chk($sformatf("vec%0d_drain", i), o_empty, 1);
            end
        end

        // Fill and overrun
        do_reset();
        clr_cnt();
        for (int k = 0; k < 9; k++) begin
            send_frame(k[7:0], 1'b1, 16);
            if (k == 6) chk("fill_not_full_7", o_full, 0);
            if (k == 7) begin
                chk("fill_full_8", o_full, 1);
                chk("fill_no_ovr_yet", n_ovr, 0);
            end
        end
        chk("overrun_pulses", n_ovr, 1);
        chk("overrun_still_full", o_full, 1);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain_%0d", k), o_data, k);
            do_read();
            if (k == 0) chk("full_clears", o_full, 0);
        end
        chk("drained_empty", o_empty, 1);
        do_read();
        chk("read_empty_ignored", o_empty, 1);
        send_frame(8'h77, 1'b1, 16);
        chk("after_empty_read_data", o_data, 8'h77);
        do_read();
        chk("after_empty_read_single", o_empty, 1);

        // Simultaneous push and pop while full
        do_reset();
        for (int k = 0; k < 8; k++) begin
            d = 8'h10 + k[7:0];
            send_frame(d, 1'b1, 16);
        end
        chk("sim_full_before", o_full, 1);
        clr_cnt();
        send_timed(8'h99, exp_edge, first);
        chk("sim_full_after", o_full, 1);
        chk("sim_no_ovr", n_ovr, 0);
        for (int k = 1; k < 8; k++) begin
            chk($sformatf("sim_drain_%0d", k), o_data, 8'h10 + k);
            do_read();
        end
        chk("sim_last_is_new", o_data, 8'h99);
        do_read();
        chk("sim_empty", o_empty, 1);

        // Glitch on an idle line
        do_reset();
        clr_cnt();
        send_level(1'b0, 4);
        send_level(1'b1, 40);
        chk("glitch_empty", o_empty, 1);
        chk("glitch_ferr", n_ferr, 0);
        send_frame(8'h42, 1'b1, 16);
        chk("post_glitch_data", o_data, 8'h42);
        do_read();

        // Stop bit held low for 40 ticks: one framing error and no retrigger
        clr_cnt();
        send_level(1'b0, 16);
        for (int i = 0; i < 8; i++) send_level(d[i] & 1'b0 | (8'h3C >> i) & 1'b1, 16);
`ifdef UART_RX_PARITY_EN
        send_level(1'b0, 16);
`endif
        send_level(1'b0, 40);
        send_level(1'b1, 200);
        chk("break_ferr_once", n_ferr, 1);
        chk("break_nothing_pushed", o_empty, 1);
        chk("break_no_perr", n_perr, 0);
        send_frame(8'hC3, 1'b1, 16);
        chk("post_break_data", o_data, 8'hC3);
        do_read();
        chk("post_break_empty", o_empty, 1);

        // Reset in the middle of bit 4 with bytes queued
        send_frame(8'h01, 1'b1, 16);
        send_frame(8'h02, 1'b1, 16);
        send_frame(8'h03, 1'b1, 16);
        chk("queued_nonempty", o_empty, 0);
        clr_cnt();
        send_level(1'b0, 16);
        for (int i = 0; i < 4; i++) send_level(1'b0, 16);
        send_level(1'b0, 8);
        i_rst = 1'b0;
        i_rx  = 1'b1;
        repeat (2) step();
        i_rst = 1'b1;
        step();
        chk("midrst_empty", o_empty, 1);
        chk("midrst_full", o_full, 0);
        send_level(1'b1, 40);
        chk("midrst_no_pulses", n_ferr + n_ovr + n_perr, 0);
        send_frame(8'h5A, 1'b1, 16);
        chk("midrst_next_data", o_data, 8'h5A);
        do_read();
        chk("midrst_next_drain", o_empty, 1);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x03 has even weight, so parity bit 0 is correct
        clr_cnt();
        send_level(1'b0, 16);
        for (int i = 0; i < 8; i++) send_level((8'h03 >> i) & 1'b1, 16);
        send_level(1'b0, 16);
        send_level(1'b1, 40);
        chk("par_good_stored", o_empty, 0);
        chk("par_good_data", o_data, 8'h03);
        chk("par_good_no_err", n_perr, 0);
        send_level(1'b0, 16);
        for (int i = 0; i < 8; i++) send_level((8'h03 >> i) & 1'b1, 16);
        send_level(1'b1, 16);
        send_level(1'b1, 40);
        chk("par_bad_pulse", n_perr, 1);
        chk("par_bad_ferr", n_ferr, 0);
        do_read();
        chk("par_bad_not_stored", o_empty, 1);
`else
        chk("no_parity_build_perr", total_perr, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
